bus_mem_responder: RTL and testbench



---
 rtl/sysbus_pkg.sv | 32 +++
 rtl/mem_array.sv | 26 ++
 rtl/bus_mem_responder.sv | 204 ++++++++++++++++++++
 tb/tb_bus_mem_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysbus_pkg.sv
// Shared system-bus definitions: tag field layout, target codes, responder states
// and the stall-LFSR step used by the memory responder.
package sysbus_pkg;

    localparam logic       SYSBUS_READ   = 1'b0;
    localparam logic       SYSBUS_WRITE  = 1'b1;
    localparam logic [3:0] SYSBUS_MEMORY = 4'h1;

    localparam int TAG_RW_BIT  = 12;
    localparam int TAG_TGT_HI  = 11;
    localparam int TAG_TGT_LO  = 8;
    localparam int TAG_ID_HI   = 7;
    localparam int TAG_ID_LO   = 0;

    localparam int LINE_BEATS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACK      = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_RD_BURST = 3'd3,
        ST_WR_DATA  = 3'd4
    } resp_state_t;

    // x^16+x^14+x^13+x^11+1, shifting right with feedback into bit 15
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic fb;
        fb = cur[0] ^ cur[2] ^ cur[3] ^ cur[5];
        return {fb, cur[15:1]};
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array: combinational read, synchronous write. Kept separate so
// it can be replaced by a vendor block-RAM wrapper.
module mem_array #(
    parameter int DATA_W = 64,
    parameter int WORDS  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [WORDS];

    // write port; contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side system-bus responder: acks line-read / line-writeback headers and
// serves 8-beat bursts from mem_array. Define MEMRESP_STALL_EN for LFSR read stalls.
module bus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int MEM_WORDS      = 4096,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    output logic                      bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      busy
);

    localparam int         IDX_W    = $clog2(MEM_WORDS);
    localparam int         LINE_W   = IDX_W - 3;
    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [2:0] LAST_BEAT = 3'(LINE_BEATS - 1);

    resp_state_t               state_r;
    logic [LINE_W-1:0]         line_r;
    logic [BUS_TAG_WIDTH-1:0]  tag_r;
    logic [2:0]                beat_r;
    logic [3:0]                lat_r;
    logic                      respcyc_r;
    logic                      reqack_r;
    logic [BUS_DATA_WIDTH-1:0] resp_r;
    logic                      busy_r;

    logic                      is_mem_s;
    logic                      is_write_s;
    logic [2:0]                rd_beat_s;
    logic                      mem_we_s;
    logic [IDX_W-1:0]          mem_addr_s;
    logic [BUS_DATA_WIDTH-1:0] mem_rdata_s;
    logic [BUS_DATA_WIDTH-1:0] rd_word_s;
    logic                      stall_next_s;

    assign is_mem_s   = (tag_r[TAG_TGT_HI:TAG_TGT_LO] == SYSBUS_MEMORY);
    assign is_write_s = (tag_r[TAG_RW_BIT] == SYSBUS_WRITE);
    assign rd_word_s  = is_mem_s ? mem_rdata_s : {BUS_DATA_WIDTH{1'b0}};

`ifdef MEMRESP_STALL_EN
    logic [15:0] lfsr_r;
    logic [15:0] lfsr_next_s;

    assign lfsr_next_s  = lfsr_step(lfsr_r);
    assign stall_next_s = lfsr_next_s[0];

    // free-running stall pattern generator
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= lfsr_next_s;
        end
    end
`else
    assign stall_next_s = 1'b0;
`endif

    // Array port steering: a line is {line_r, beat}, so beat offsets need no adder.
    // Reads look up the beat about to be presented so resp can be registered.
    always_comb begin
        mem_we_s   = 1'b0;
        mem_addr_s = {IDX_W{1'b0}};
        rd_beat_s  = 3'd0;
        if (state_r == ST_RD_BURST) begin
            rd_beat_s = beat_r + 3'd1;
        end else begin
            rd_beat_s = 3'd0;
        end
        if (state_r == ST_WR_DATA) begin
            mem_we_s   = bus_reqcyc & is_mem_s & ~reset;
            mem_addr_s = {line_r, beat_r};
        end else begin
            mem_we_s   = 1'b0;
            mem_addr_s = {line_r, rd_beat_s};
        end
    end

    mem_array #(
        .DATA_W (BUS_DATA_WIDTH),
        .WORDS  (MEM_WORDS),
        .ADDR_W (IDX_W)
    ) u_mem (
        .clk    (clk),
        .we     (mem_we_s),
        .addr   (mem_addr_s),
        .wdata  (bus_req),
        .rdata  (mem_rdata_s)
    );

    // responder FSM with registered bus outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            line_r    <= {LINE_W{1'b0}};
            tag_r     <= {BUS_TAG_WIDTH{1'b0}};
            beat_r    <= 3'd0;
            lat_r     <= 4'd0;
            respcyc_r <= 1'b0;
            reqack_r  <= 1'b0;
            resp_r    <= {BUS_DATA_WIDTH{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    respcyc_r <= 1'b0;
                    resp_r    <= {BUS_DATA_WIDTH{1'b0}};
                    beat_r    <= 3'd0;
                    if (bus_reqcyc) begin
                        line_r   <= bus_req[IDX_W+2:6];
                        tag_r    <= bus_reqtag;
                        reqack_r <= 1'b1;
                        busy_r   <= 1'b1;
                        state_r  <= ST_ACK;
                    end else begin
                        reqack_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                ST_ACK: begin
                    reqack_r <= 1'b0;
                    beat_r   <= 3'd0;
                    if (is_write_s) begin
                        state_r <= ST_WR_DATA;
                    end else if (READ_LATENCY == 1) begin
                        state_r   <= ST_RD_BURST;
                        respcyc_r <= ~stall_next_s;
                        resp_r    <= rd_word_s;
                    end else begin
                        state_r <= ST_RD_WAIT;
                        lat_r   <= LAT_LOAD;
                    end
                end
                ST_RD_WAIT: begin
                    // lat_r reaching zero on this edge starts the burst
                    if (lat_r == 4'd1) begin
                        lat_r     <= 4'd0;
                        state_r   <= ST_RD_BURST;
                        respcyc_r <= ~stall_next_s;
                        resp_r    <= rd_word_s;
                    end else begin
                        lat_r <= lat_r - 4'd1;
                    end
                end
                ST_RD_BURST: begin
                    if (respcyc_r && bus_respack) begin
                        if (beat_r == LAST_BEAT) begin
                            beat_r    <= 3'd0;
                            respcyc_r <= 1'b0;
                            resp_r    <= {BUS_DATA_WIDTH{1'b0}};
                            busy_r    <= 1'b0;
                            state_r   <= ST_IDLE;
                        end else begin
                            beat_r    <= rd_beat_s;
                            resp_r    <= rd_word_s;
                            respcyc_r <= ~stall_next_s;
                        end
                    end else begin
                        respcyc_r <= ~stall_next_s;
                    end
                end
                ST_WR_DATA: begin
                    if (bus_reqcyc) begin
                        beat_r <= beat_r + 3'd1;
                        if (beat_r == LAST_BEAT) begin
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            busy_r <= 1'b1;
                        end
                    end else begin
                        beat_r <= beat_r;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    respcyc_r <= 1'b0;
                    reqack_r  <= 1'b0;
                    resp_r    <= {BUS_DATA_WIDTH{1'b0}};
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus_respcyc = respcyc_r;
    assign bus_reqack  = reqack_r;
    assign bus_resp    = resp_r;
    assign bus_resptag = tag_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: randomized bus traffic against a
// line-level memory model; covers MEMRESP_STALL_EN when that macro is defined.
module tb_bus_mem_responder;
    import sysbus_pkg::*;

    localparam int READ_LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_reqcyc;
    logic        bus_respack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_respcyc;
    logic        bus_reqack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_busy;

    int errors = 0;
    int checks = 0;

    logic [63:0] model_mem [4096];

    logic [63:0] wr_data [8];
    logic        wr_ack, wr_busy_mid, wr_busy_end;

    logic [63:0] rd_data [8];
    logic        rd_ack, rd_timeout, rd_end_ok;
    int          rd_lat, rd_ncyc, rd_k, rd_extra_ack, rd_tag_err, rd_gap_err;

    bus_mem_responder #(
        .BUS_TAG_WIDTH  (13),
        .BUS_DATA_WIDTH (64),
        .MEM_WORDS      (4096),
        .READ_LATENCY   (READ_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_respack (bus_respack),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respcyc (bus_respcyc),
        .bus_reqack  (bus_reqack),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .busy        (bus_busy)
    );

    always #5 clk = ~clk;

`ifdef MEMRESP_STALL_EN
    logic [15:0] tb_lfsr;
    always @(posedge clk) begin
        if (reset) tb_lfsr <= 16'hACE1;
        else       tb_lfsr <= {tb_lfsr[0] ^ tb_lfsr[2] ^ tb_lfsr[3] ^ tb_lfsr[5], tb_lfsr[15:1]};
    end
`endif

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] mk_tag(input logic wr, input logic [3:0] tgt, input logic [7:0] id);
        return {wr, tgt, id};
    endfunction

    function automatic int widx(input logic [63:0] a, input int b);
        return int'(a[14:6]) * 8 + b;
    endfunction

    task automatic run_write(input logic [63:0] addr, input logic [12:0] tag,
                             input int gap_after, input bit rand_gaps);
        bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag;
        cyc();
        wr_ack = bus_reqack;
        bus_reqcyc = 1'b0; bus_req = 64'd0;
        cyc();
        wr_busy_mid = bus_busy;
        wr_busy_end = 1'b1;
        for (int b = 0; b < 8; b++) begin
            bus_reqcyc = 1'b1; bus_req = wr_data[b];
            cyc();
            bus_reqcyc = 1'b0; bus_req = 64'd0;
            if (b == 7) wr_busy_end = bus_busy;
            if (b == gap_after || (rand_gaps && $urandom_range(0, 1) == 1)) cyc();
        end
        if (tag[TAG_TGT_HI:TAG_TGT_LO] == SYSBUS_MEMORY) begin
            for (int b = 0; b < 8; b++) model_mem[widx(addr, b)] = wr_data[b];
        end
    endtask

    task automatic run_read(input logic [63:0] addr, input logic [12:0] tag,
                            input int hold_beat, input int hold_cycles,
                            input bit rand_ack, input bit hold_req, input int abort_at);
        int  t, held;
        bit  done;
        logic exp_cyc;
        rd_ack = 1'b0; rd_lat = -1; rd_ncyc = 0; rd_k = 0; rd_extra_ack = 0;
        rd_tag_err = 0; rd_gap_err = 0; rd_timeout = 1'b0; rd_end_ok = 1'b1;
        held = 0; t = 0; done = 1'b0;
        bus_respack = 1'b0;
        bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag;
        cyc();
        rd_ack = bus_reqack;
        if (!hold_req) bus_reqcyc = 1'b0;
        while (!done && t < 100) begin
            cyc();
            t++;
            if (bus_reqack) rd_extra_ack++;
            exp_cyc = (t >= READ_LAT);
`ifdef MEMRESP_STALL_EN
            exp_cyc = exp_cyc & ~tb_lfsr[0];
`endif
            if (bus_respcyc !== exp_cyc) rd_gap_err++;
            bus_respack = 1'b0;
            if (bus_respcyc) begin
                bus_reqcyc = 1'b0;
                if (rd_lat < 0) rd_lat = t;
                rd_ncyc++;
                if (bus_resptag !== tag) rd_tag_err++;
                if (rd_k == abort_at) begin
                    done = 1'b1;
                end else if (rd_k == hold_beat && held < hold_cycles) begin
                    held++;
                end else if (rand_ack && $urandom_range(0, 3) == 0) begin
                    held = held;
                end else begin
                    bus_respack = 1'b1;
                    rd_data[rd_k] = bus_resp;
                    rd_k++;
                    if (rd_k == 8) done = 1'b1;
                end
            end
        end
        bus_reqcyc = 1'b0;
        if (!done) rd_timeout = 1'b1;
        if (abort_at < 0) begin
            cyc();
            bus_respack = 1'b0;
            rd_end_ok = (bus_respcyc === 1'b0) && (bus_busy === 1'b0) && (bus_resp === 64'd0);
        end
    endtask

    // common per-read checks; exp_ncyc < 0 skips the cycle-count check
    task automatic check_read(input string nm, input logic [63:0] addr, input logic [12:0] tag,
                              input bit zeros, input int exp_ncyc);
        logic [63:0] exp;
        checks++; if (rd_ack !== 1'b1) begin errors++; $display("FAIL %s ack: got %b expected 1", nm, rd_ack); end
        checks++; if (rd_timeout !== 1'b0) begin errors++; $display("FAIL %s timeout: burst incomplete after 100 cycles, beats=%0d expected 8", nm, rd_k); end
`ifdef MEMRESP_STALL_EN
        checks++; if (rd_lat < READ_LAT) begin errors++; $display("FAIL %s latency: got %0d expected >= %0d", nm, rd_lat, READ_LAT); end
`else
        checks++; if (rd_lat !== READ_LAT) begin errors++; $display("FAIL %s latency: got %0d expected %0d", nm, rd_lat, READ_LAT); end
`endif
        checks++; if (rd_gap_err !== 0) begin errors++; $display("FAIL %s respcyc_pattern: got %0d bad cycles expected 0", nm, rd_gap_err); end
        checks++; if (rd_extra_ack !== 0) begin errors++; $display("FAIL %s extra_ack: got %0d expected 0", nm, rd_extra_ack); end
        checks++; if (rd_tag_err !== 0) begin errors++; $display("FAIL %s resptag: got %0d bad beats expected 0 (tag %h)", nm, rd_tag_err, tag); end
        checks++; if (rd_end_ok !== 1'b1) begin errors++; $display("FAIL %s burst_end: got respcyc=%b busy=%b resp=%h expected 0/0/0", nm, bus_respcyc, bus_busy, bus_resp); end
        if (exp_ncyc >= 0) begin
            checks++; if (rd_ncyc !== exp_ncyc) begin errors++; $display("FAIL %s respcyc_count: got %0d expected %0d", nm, rd_ncyc, exp_ncyc); end
        end
        for (int j = 0; j < 8; j++) begin
            exp = zeros ? 64'd0 : model_mem[widx(addr, j)];
            checks++;
            if (rd_data[j] !== exp) begin errors++; $display("FAIL %s data beat %0d: got %h expected %h", nm, j, rd_data[j], exp); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus_reqcyc = 1'b0; bus_respack = 1'b0; bus_req = 64'd0; bus_reqtag = 13'd0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        checks++; if (bus_respcyc !== 1'b0) begin errors++; $display("FAIL reset respcyc: got %b expected 0", bus_respcyc); end
        checks++; if (bus_reqack !== 1'b0) begin errors++; $display("FAIL reset reqack: got %b expected 0", bus_reqack); end
        checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", bus_busy); end
        checks++; if (bus_resp !== 64'd0) begin errors++; $display("FAIL reset resp: got %h expected 0", bus_resp); end
        checks++; if (bus_resptag !== 13'd0) begin errors++; $display("FAIL reset resptag: got %h expected 0", bus_resptag); end
    endtask

    task automatic test_basic_read();
        for (int j = 0; j < 8; j++) wr_data[j] = 64'h1008 + 64'(j);
        run_write(64'h200, mk_tag(SYSBUS_WRITE, SYSBUS_MEMORY, 8'h01), -1, 1'b0);
        checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL preload ack: got %b expected 1", wr_ack); end
        run_read(64'h0000_0208, 13'h0105, -1, 0, 1'b0, 1'b0, -1);
        check_read("basic_read", 64'h208, 13'h0105, 1'b0, 8);
        checks++; if (rd_data[0] !== 64'h1008 || rd_data[7] !== 64'h100F) begin
            errors++; $display("FAIL basic_read endpoints: got %h..%h expected 1008..100f", rd_data[0], rd_data[7]);
        end
    endtask

    task automatic test_hold();
        run_read(64'h208, 13'h0105, 3, 2, 1'b0, 1'b0, -1);
        check_read("hold_beat3", 64'h208, 13'h0105, 1'b0, 10);
    endtask

    task automatic test_write_gap();
        for (int j = 0; j < 8; j++) wr_data[j] = 64'hA0 + 64'(j);
        run_write(64'h1C0, mk_tag(SYSBUS_WRITE, SYSBUS_MEMORY, 8'h10), 2, 1'b0);
        checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL write_gap ack: got %b expected 1", wr_ack); end
        checks++; if (wr_busy_mid !== 1'b1) begin errors++; $display("FAIL write_gap busy_mid: got %b expected 1", wr_busy_mid); end
        checks++; if (wr_busy_end !== 1'b0) begin errors++; $display("FAIL write_gap busy_end: got %b expected 0", wr_busy_end); end
        run_read(64'h1C0, mk_tag(SYSBUS_READ, SYSBUS_MEMORY, 8'h11), -1, 0, 1'b0, 1'b0, -1);
        check_read("write_gap_readback", 64'h1C0, mk_tag(SYSBUS_READ, SYSBUS_MEMORY, 8'h11), 1'b0, 8);
    endtask

    task automatic test_reset_mid_burst();
        run_read(64'h200, 13'h0105, -1, 0, 1'b0, 1'b0, 4);
        checks++; if (rd_k !== 4) begin errors++; $display("FAIL reset_mid beats_before: got %0d expected 4", rd_k); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++; if (bus_respcyc !== 1'b0) begin errors++; $display("FAIL reset_mid respcyc: got %b expected 0", bus_respcyc); end
        checks++; if (bus_reqack !== 1'b0) begin errors++; $display("FAIL reset_mid reqack: got %b expected 0", bus_reqack); end
        checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy: got %b expected 0", bus_busy); end
        run_read(64'h208, 13'h0122, -1, 0, 1'b0, 1'b0, -1);
        check_read("after_reset_read", 64'h208, 13'h0122, 1'b0, 8);
    endtask

    task automatic test_other_target();
        for (int j = 0; j < 8; j++) wr_data[j] = {$urandom, $urandom};
        run_write(64'h200, mk_tag(SYSBUS_WRITE, 4'h2, 8'h33), -1, 1'b1);
        checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL other_write ack: got %b expected 1", wr_ack); end
        run_read(64'h200, mk_tag(SYSBUS_READ, 4'h2, 8'h05), -1, 0, 1'b0, 1'b0, -1);
        check_read("other_read", 64'h200, mk_tag(SYSBUS_READ, 4'h2, 8'h05), 1'b1, 8);
        run_read(64'h200, 13'h0105, -1, 0, 1'b0, 1'b0, -1);
        check_read("other_unmodified", 64'h200, 13'h0105, 1'b0, 8);
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [12:0] rt;
        for (int i = 0; i < 8; i++) begin
            a = {$urandom, $urandom};
            for (int j = 0; j < 8; j++) wr_data[j] = {$urandom, $urandom};
            run_write(a, mk_tag(SYSBUS_WRITE, SYSBUS_MEMORY, 8'(i)), -1, 1'b1);
            checks++; if (wr_busy_end !== 1'b0) begin errors++; $display("FAIL random_write%0d busy_end: got %b expected 0", i, wr_busy_end); end
            rt = mk_tag(SYSBUS_READ, SYSBUS_MEMORY, 8'($urandom_range(0, 255)));
            run_read(a ^ 64'h3F, rt, -1, 0, 1'b1, 1'(i % 2), -1);
            check_read("random_read", a, rt, 1'b0, -1);
        end
    endtask

    // read immediately followed by a header in the first idle cycle
    task automatic test_back_to_back();
        run_read(64'h1C0, 13'h0140, -1, 0, 1'b0, 1'b0, -1);
        check_read("b2b_first", 64'h1C0, 13'h0140, 1'b0, 8);
        run_read(64'h208, 13'h0141, -1, 0, 1'b1, 1'b0, -1);
        check_read("b2b_second", 64'h208, 13'h0141, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_hold();
        test_write_gap();
        test_reset_mid_burst();
        test_other_target();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
